// File: rtl/ahb_master_req_ctrl.sv
// AHB master request/burst controller: requests the slave arbiter, issues one burst's address phases, tracks data phases.
// Latency: hreq one cycle after command accept, first NONSEQ the cycle after hgrant; no new command until burst_done.
module ahb_master_req_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int MAX_INCR_BEATS = 16
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [2:0]        cmd_burst,
    input  logic [3:0]        cmd_len,
    output logic              hreq,
    input  logic              hgrant,
    input  logic              hready,
    output logic [1:0]        htrans,
    output logic [ADDR_W-1:0] haddr,
    output logic [2:0]        hburst,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic              beat_done,
    output logic              burst_done,
    output logic              busy
);

    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_INCR   = 3'd1;
    localparam logic [2:0] B_WRAP4  = 3'd2;
    localparam logic [2:0] B_INCR4  = 3'd3;
    localparam logic [2:0] B_WRAP8  = 3'd4;
    localparam logic [2:0] B_INCR8  = 3'd5;
    localparam logic [2:0] B_WRAP16 = 3'd6;
    localparam logic [2:0] B_INCR16 = 3'd7;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    localparam logic [3:0] INCR_CAP = 4'(MAX_INCR_BEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ADDR, S_DRAIN} state_t;

    state_t            state, state_nxt;
    logic [3:0]        beat_cnt;
    logic [3:0]        last_beat;
    logic [3:0]        last_beat_cmd;
    logic              dphase;
    logic              accept;
    logic              last_accept;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W-1:0] wrap_mask;
    logic              is_wrap;

    // Stored as beats-1 so the counter compare needs no extra bit for 16-beat bursts.
    always_comb begin
        last_beat_cmd = 4'd0;
        case (cmd_burst)
            B_SINGLE:          last_beat_cmd = 4'd0;
            B_INCR:            last_beat_cmd = (cmd_len > INCR_CAP) ? INCR_CAP : cmd_len;
            B_WRAP4, B_INCR4:  last_beat_cmd = 4'd3;
            B_WRAP8, B_INCR8:  last_beat_cmd = 4'd7;
            B_WRAP16, B_INCR16: last_beat_cmd = 4'd15;
            default:           last_beat_cmd = 4'd0;
        endcase
    end

    always_comb begin
        wrap_mask = '0;
        is_wrap   = 1'b0;
        case (hburst)
            B_WRAP4:  begin wrap_mask = ADDR_W'(6'h0F); is_wrap = 1'b1; end
            B_WRAP8:  begin wrap_mask = ADDR_W'(6'h1F); is_wrap = 1'b1; end
            B_WRAP16: begin wrap_mask = ADDR_W'(6'h3F); is_wrap = 1'b1; end
            default:  begin wrap_mask = '0; is_wrap = 1'b0; end
        endcase
        addr_inc = haddr + ADDR_W'(4);
        addr_nxt = is_wrap ? ((haddr & ~wrap_mask) | (addr_inc & wrap_mask)) : addr_inc;
    end

    assign accept      = (state == S_ADDR) && hgrant && hready;
    assign last_accept = accept && (beat_cnt == last_beat);

    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        hreq       = 1'b0;
        htrans     = T_IDLE;
        burst_done = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = S_REQ;
            end
            S_REQ: begin
                hreq = 1'b1;
                if (hgrant) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                hreq   = 1'b1;
                htrans = (beat_cnt == 4'd0) ? T_NONSEQ : T_SEQ;
                if (last_accept) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // dphase is always set here: the last beat was accepted on entry.
                if (hready) begin
                    burst_done = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign hsize     = 3'b010;
    assign beat_done = dphase && hready;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= S_IDLE;
            beat_cnt  <= 4'd0;
            last_beat <= 4'd0;
            haddr     <= '0;
            hburst    <= B_SINGLE;
            hwrite    <= 1'b0;
            dphase    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && cmd_valid) begin
                haddr     <= cmd_addr & ~ADDR_W'(3);
                hwrite    <= cmd_write;
                hburst    <= cmd_burst;
                last_beat <= last_beat_cmd;
                beat_cnt  <= 4'd0;
            end
            if (accept) begin
                beat_cnt <= beat_cnt + 4'd1;
                if (!last_accept) haddr <= addr_nxt;
            end
            if (accept)      dphase <= 1'b1;
            else if (hready) dphase <= 1'b0;
        end
    end

endmodule
